vmc_change_sequencer: RTL

//  Sequences change return for the vending machine controller. Accepts a change amount in

---
 rtl/vmc_pkg.sv | 26 ++
 rtl/vmc_pulse_timer.sv | 28 ++
 rtl/vmc_change_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/vmc_pkg.sv
// rtl/vmc_pkg.sv - shared state codes, denomination codes and coin values for the change sequencer
package vmc_pkg;

    localparam int VMC_AMT_W = 8;

    // FSM state codes kept as plain constants so older tools and wrappers can match on them
    typedef logic [2:0] vmc_chg_state_t;
    localparam vmc_chg_state_t ST_IDLE     = 3'd0;
    localparam vmc_chg_state_t ST_SELECT   = 3'd1;
    localparam vmc_chg_state_t ST_PULSE    = 3'd2;
    localparam vmc_chg_state_t ST_WAIT_ACK = 3'd3;
    localparam vmc_chg_state_t ST_FINISH   = 3'd4;

    // Which coin the greedy selector picked
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_1    = 2'd1,
        SEL_5    = 2'd2,
        SEL_10   = 2'd3
    } vmc_denom_t;

    localparam logic [VMC_AMT_W-1:0] DENOM_1  = 8'd1;
    localparam logic [VMC_AMT_W-1:0] DENOM_5  = 8'd5;
    localparam logic [VMC_AMT_W-1:0] DENOM_10 = 8'd10;

endpackage

// File: rtl/vmc_pulse_timer.sv
// rtl/vmc_pulse_timer.sv - loadable down-counter that flags the last cycle of a timed interval
module vmc_pulse_timer #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_expire
);

    logic [W-1:0] r_cnt;

    // Reload on request, otherwise count down and park at zero
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    // High during the final cycle of an interval of i_value cycles
    assign o_expire = (r_cnt == W'(1));

endmodule

// File: rtl/vmc_change_sequencer.sv
// rtl/vmc_change_sequencer.sv - greedy coin change sequencer driving a hopper with handshaked pulses
module vmc_change_sequencer
    import vmc_pkg::*;
#(
    parameter int AMT_W     = 8,
    parameter int INV_W     = 6,
    parameter int INV_INIT  = 20,
    parameter int PULSE_CYC = 2,
    parameter int ACK_TO    = 8
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_req,
    input  logic [AMT_W-1:0] i_amount,
    input  logic             i_refill,
    input  logic             i_hop_ack,
    output logic             o_c10,
    output logic             o_c5,
    output logic             o_c1,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_short,
    output logic             o_fault,
    output logic [AMT_W-1:0] o_remain,
    output logic [INV_W-1:0] o_inv10,
    output logic [INV_W-1:0] o_inv5,
    output logic [INV_W-1:0] o_inv1
);

    localparam int TMR_W = 8;

    vmc_chg_state_t   r_state;
    vmc_denom_t       r_denom;
    logic [AMT_W-1:0] r_rem;
    logic [INV_W-1:0] r_inv10, r_inv5, r_inv1;
    logic             r_c10, r_c5, r_c1;
    logic             r_short, r_fault;

    vmc_denom_t       w_sel;
    logic [AMT_W-1:0] w_denom_val;
    logic             w_tmr_load;
    logic [TMR_W-1:0] w_tmr_value;
    logic             w_tmr_exp;

    // Greedy pick: largest coin that fits the remaining amount and is still in stock
    always_comb begin
        w_sel = SEL_NONE;
        if (r_rem >= AMT_W'(DENOM_10) && r_inv10 != '0) begin
            w_sel = SEL_10;
        end else if (r_rem >= AMT_W'(DENOM_5) && r_inv5 != '0) begin
            w_sel = SEL_5;
        end else if (r_rem >= AMT_W'(DENOM_1) && r_inv1 != '0) begin
            w_sel = SEL_1;
        end
    end

    // Value of the coin currently being paid out
    always_comb begin
        w_denom_val = '0;
        case (r_denom)
            SEL_10:  w_denom_val = AMT_W'(DENOM_10);
            SEL_5:   w_denom_val = AMT_W'(DENOM_5);
            SEL_1:   w_denom_val = AMT_W'(DENOM_1);
            default: w_denom_val = '0;
        endcase
    end

    // One timer serves both the pulse width and the ack timeout
    assign w_tmr_load  = (r_state == ST_SELECT && w_sel != SEL_NONE) ||
                         (r_state == ST_PULSE && w_tmr_exp);
    assign w_tmr_value = (r_state == ST_SELECT) ? TMR_W'(PULSE_CYC) : TMR_W'(ACK_TO);

    vmc_pulse_timer #(.W(TMR_W)) u_timer (
        .i_clk    (i_clock),
        .i_rst    (i_reset),
        .i_load   (w_tmr_load),
        .i_value  (w_tmr_value),
        .o_expire (w_tmr_exp)
    );

    // Sequencer FSM with amount, inventory and registered coin outputs
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_denom <= SEL_NONE;
            r_rem   <= '0;
            r_inv10 <= INV_W'(INV_INIT);
            r_inv5  <= INV_W'(INV_INIT);
            r_inv1  <= INV_W'(INV_INIT);
            r_c10   <= 1'b0;
            r_c5    <= 1'b0;
            r_c1    <= 1'b0;
            r_short <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req) begin
                        r_rem   <= i_amount;
                        r_fault <= 1'b0;
                        r_short <= 1'b0;
                        r_state <= ST_SELECT;
                    end else if (i_refill) begin
                        r_inv10 <= INV_W'(INV_INIT);
                        r_inv5  <= INV_W'(INV_INIT);
                        r_inv1  <= INV_W'(INV_INIT);
                    end
                end
                ST_SELECT: begin
                    if (w_sel != SEL_NONE) begin
                        r_denom <= w_sel;
                        r_c10   <= (w_sel == SEL_10);
                        r_c5    <= (w_sel == SEL_5);
                        r_c1    <= (w_sel == SEL_1);
                        r_state <= ST_PULSE;
                    end else begin
                        // Nothing payable: short only if money is still owed
                        r_short <= (r_rem != '0);
                        r_state <= ST_FINISH;
                    end
                end
                ST_PULSE: begin
                    if (w_tmr_exp) begin
                        r_c10   <= 1'b0;
                        r_c5    <= 1'b0;
                        r_c1    <= 1'b0;
                        r_state <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (i_hop_ack) begin
                        r_rem <= r_rem - w_denom_val;
                        case (r_denom)
                            SEL_10:  r_inv10 <= r_inv10 - INV_W'(1);
                            SEL_5:   r_inv5  <= r_inv5 - INV_W'(1);
                            SEL_1:   r_inv1  <= r_inv1 - INV_W'(1);
                            default: ;
                        endcase
                        r_state <= ST_SELECT;
                    end else if (w_tmr_exp) begin
                        r_fault <= 1'b1;
                        r_short <= 1'b1;
                        r_state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_c10    = r_c10;
    assign o_c5     = r_c5;
    assign o_c1     = r_c1;
    assign o_busy   = (r_state != ST_IDLE);
    assign o_done   = (r_state == ST_FINISH);
    assign o_short  = r_short;
    assign o_fault  = r_fault;
    assign o_remain = r_rem;
    assign o_inv10  = r_inv10;
    assign o_inv5   = r_inv5;
    assign o_inv1   = r_inv1;

endmodule
